button_conditioner: RTL and testbench

- Input stage in front of the dice-roll counter/display logic.
- Takes the 7 raw, bouncing die-select buttons and synchronises them, then debounces them on the shared 32 Hz prescaler tick.
- Produces debounced levels, single-cycle press/release events with an encoded button index, and hold/auto-repeat events for the downstream roll counter.
- Replaces the per-button debouncer instances with one block.

---
 rtl/button_conditioner.sv | 156 +++++++++++++++
 tb/tb_button_conditioner.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Purpose : two-flop synchronise, tick-based debounce, press/release edge events
//           and hold/auto-repeat events for the die-select buttons.
// Latency : raw edge -> btn_deb after 2 clk + DEB_SAMPLES ticks; pulses 1 clk after btn_deb.
// Backpr. : none; every event is a single-cycle pulse that the consumer must take.
//
// Ports:
//   clk, rst       system clock, synchronous active-high reset
//   tick           one-cycle sample strobe from the shared prescaler
//   btn_raw        asynchronous raw buttons (active-high)
//   btn_deb        debounced levels
//   any_held       registered OR of the debounced levels
//   press_pulse    any debounced bit rose; press_code = lowest rising index,
//                  press_mask = all rising bits
//   release_pulse  debounced set went from nonzero to empty
//   hold_pulse     first hold event and each auto-repeat while held
module button_conditioner #(
  parameter int NBTN         = 7,
  parameter int DEB_SAMPLES  = 4,
  parameter int HOLD_TICKS   = 16,
  parameter int REPEAT_TICKS = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            tick,
  input  logic [NBTN-1:0] btn_raw,
  output logic [NBTN-1:0] btn_deb,
  output logic            any_held,
  output logic            press_pulse,
  output logic [2:0]      press_code,
  output logic [NBTN-1:0] press_mask,
  output logic            release_pulse,
  output logic            hold_pulse
);

  localparam int CW = $clog2(DEB_SAMPLES + 1);

  typedef enum logic [1:0] {IDLE, PRESSED, HELD} state_t;

  logic [NBTN-1:0] sync1, sync2;
  logic [NBTN-1:0] deb_nxt;
  logic [NBTN-1:0] btn_deb_d;
  logic [NBTN-1:0] rise;
  logic [CW-1:0]   cnt     [NBTN];
  logic [CW-1:0]   cnt_nxt [NBTN];
  logic [2:0]      code_nxt;

  state_t          state, state_nxt;
  logic [7:0]      hold_cnt, hold_cnt_nxt;
  logic            hold_fire;

  // Per-bit debounce: any sample that agrees with the current level restarts the count.
  always_comb begin
    for (int i = 0; i < NBTN; i++) begin
      deb_nxt[i] = btn_deb[i];
      cnt_nxt[i] = cnt[i];
      if (tick) begin
        if (sync2[i] != btn_deb[i]) begin
          if (cnt[i] + 1'b1 == CW'(DEB_SAMPLES)) begin
            deb_nxt[i] = ~btn_deb[i];
            cnt_nxt[i] = '0;
          end else begin
            cnt_nxt[i] = cnt[i] + 1'b1;
          end
        end else begin
          cnt_nxt[i] = '0;
        end
      end
    end
  end

  assign rise = btn_deb & ~btn_deb_d;

  // Lowest set index wins; scanning downward leaves the lowest one last.
  always_comb begin
    code_nxt = press_code;
    for (int i = NBTN - 1; i >= 0; i--) begin
      if (rise[i]) code_nxt = 3'(i);
    end
  end

  // Hold FSM. Release is judged on the level btn_deb takes at this edge, so a
  // release landing on the same tick as a hold/repeat event suppresses it.
  always_comb begin
    state_nxt    = state;
    hold_cnt_nxt = hold_cnt;
    hold_fire    = 1'b0;
    if (deb_nxt == '0) begin
      state_nxt    = IDLE;
      hold_cnt_nxt = '0;
    end else if (press_pulse) begin
      state_nxt    = PRESSED;
      hold_cnt_nxt = '0;
    end else begin
      case (state)
        PRESSED: begin
          if (tick) begin
            if (hold_cnt + 8'd1 == 8'(HOLD_TICKS)) begin
              state_nxt    = HELD;
              hold_cnt_nxt = '0;
              hold_fire    = 1'b1;
            end else begin
              hold_cnt_nxt = hold_cnt + 8'd1;
            end
          end
        end
        HELD: begin
          if (tick) begin
            if (hold_cnt + 8'd1 == 8'(REPEAT_TICKS)) begin
              hold_cnt_nxt = '0;
              hold_fire    = 1'b1;
            end else begin
              hold_cnt_nxt = hold_cnt + 8'd1;
            end
          end
        end
        default: begin
          state_nxt    = IDLE;
          hold_cnt_nxt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1         <= '0;
      sync2         <= '0;
      btn_deb       <= '0;
      btn_deb_d     <= '0;
      for (int i = 0; i < NBTN; i++) cnt[i] <= '0;
      any_held      <= 1'b0;
      press_pulse   <= 1'b0;
      press_code    <= 3'd0;
      press_mask    <= '0;
      release_pulse <= 1'b0;
      hold_pulse    <= 1'b0;
      state         <= IDLE;
      hold_cnt      <= '0;
    end else begin
      sync1         <= btn_raw;
      sync2         <= sync1;
      btn_deb       <= deb_nxt;
      btn_deb_d     <= btn_deb;
      for (int i = 0; i < NBTN; i++) cnt[i] <= cnt_nxt[i];
      any_held      <= |btn_deb;
      press_pulse   <= |rise;
      press_code    <= code_nxt;
      press_mask    <= rise;
      release_pulse <= (btn_deb_d != '0) && (btn_deb == '0);
      hold_pulse    <= hold_fire;
      state         <= state_nxt;
      hold_cnt      <= hold_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
module tb_button_conditioner;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic [6:0] btn_raw;
  logic [6:0] btn_deb;
  logic       any_held;
  logic       press_pulse;
  logic [2:0] press_code;
  logic [6:0] press_mask;
  logic       release_pulse;
  logic       hold_pulse;

  int vectors = 0;
  int errors  = 0;

  button_conditioner dut (
    .clk           (clk),
    .rst           (rst),
    .tick          (tick),
    .btn_raw       (btn_raw),
    .btn_deb       (btn_deb),
    .any_held      (any_held),
    .press_pulse   (press_pulse),
    .press_code    (press_code),
    .press_mask    (press_mask),
    .release_pulse (release_pulse),
    .hold_pulse    (hold_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock edge; results of that edge are visible on return.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Seven idle edges then one edge with tick asserted.
  task automatic tick8();
    repeat (7) cyc();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
  endtask

  // Apply a raw level and let it debounce over four ticks.
  task automatic settle(input logic [6:0] v);
    btn_raw = v;
    repeat (4) tick8();
  endtask

  initial begin
    rst     = 1'b1;
    tick    = 1'b0;
    btn_raw = 7'h7F;

    // Reset with all buttons down
    repeat (3) cyc();
    check("rst_deb",     btn_deb,       0);
    check("rst_held",    any_held,      0);
    check("rst_press",   press_pulse,   0);
    check("rst_code",    press_code,    0);
    check("rst_mask",    press_mask,    0);
    check("rst_release", release_pulse, 0);
    check("rst_hold",    hold_pulse,    0);

    rst = 1'b0;
    repeat (3) tick8();
    check("deb_3ticks", btn_deb, 7'h00);
    tick8();
    check("deb_4ticks", btn_deb, 7'h7F);
    check("pulse_not_yet", press_pulse, 0);
    cyc();
    check("all_press",  press_pulse, 1);
    check("all_code",   press_code,  0);
    check("all_mask",   press_mask,  7'h7F);
    check("all_held",   any_held,    1);
    cyc();
    check("all_press_1cyc", press_pulse, 0);
    check("all_mask_clr",   press_mask,  0);

    settle(7'h00);
    check("all_rel_deb", btn_deb, 0);
    cyc();
    check("all_release", release_pulse, 1);
    check("all_rel_held", any_held, 0);
    cyc();
    check("all_release_1cyc", release_pulse, 0);

    // Bounce on bit 2: samples 1,0,1,1,1,1
    btn_raw = 7'h04; tick8();
    btn_raw = 7'h00; tick8();
    btn_raw = 7'h04; tick8();
    tick8();
    tick8();
    check("bnc_not_yet", btn_deb, 7'h00);
    tick8();
    check("bnc_deb", btn_deb, 7'h04);
    cyc();
    check("bnc_press", press_pulse, 1);
    check("bnc_code",  press_code,  2);
    check("bnc_mask",  press_mask,  7'h04);
    cyc();
    check("bnc_press_1cyc", press_pulse, 0);
    settle(7'h00);
    cyc();
    check("bnc_release", release_pulse, 1);

    // Simultaneous press of bits 5 and 3
    settle(7'h28);
    cyc();
    check("sim_press", press_pulse, 1);
    check("sim_code",  press_code,  3);
    check("sim_mask",  press_mask,  7'h28);
    cyc();
    check("sim_code_holds", press_code, 3);
    check("sim_mask_clr",   press_mask, 0);
    settle(7'h00);
    cyc();
    check("sim_release", release_pulse, 1);

    // Hold / repeat on bit 6
    settle(7'h40);
    cyc();
    check("hold_press", press_pulse, 1);
    check("hold_code",  press_code,  6);
    for (int k = 1; k <= 24; k++) begin
      tick8();
      check($sformatf("hold_t%0d", k), hold_pulse, (k == 16 || k == 20 || k == 24) ? 1 : 0);
    end
    cyc();
    check("hold_1cyc", hold_pulse, 0);
    // Release debounces on tick 28, which coincides with a repeat slot
    settle(7'h00);
    check("hold_rel_no_rep", hold_pulse, 0);
    check("hold_rel_deb",    btn_deb,    0);
    cyc();
    check("hold_release", release_pulse, 1);
    cyc();
    check("hold_release_1cyc", release_pulse, 0);
    for (int k = 0; k < 6; k++) begin
      tick8();
      check($sformatf("idle_t%0d", k), hold_pulse, 0);
    end

    // Release lands on the tick where the first hold would fire
    settle(7'h40);
    cyc();
    check("col_press", press_pulse, 1);
    repeat (12) tick8();
    settle(7'h00);
    check("col_hold_suppressed", hold_pulse, 0);
    check("col_deb",             btn_deb,    0);
    cyc();
    check("col_release",   release_pulse, 1);
    check("col_hold_none", hold_pulse,    0);

    // Partial release
    settle(7'h03);
    cyc();
    check("part_press", press_pulse, 1);
    check("part_code",  press_code,  0);
    check("part_mask",  press_mask,  7'h03);
    settle(7'h01);
    check("part_deb", btn_deb, 7'h01);
    cyc();
    check("part_no_release", release_pulse, 0);
    check("part_held",       any_held,      1);
    check("part_no_press",   press_pulse,   0);
    settle(7'h00);
    cyc();
    check("part_release", release_pulse, 1);
    check("part_held_clr", any_held, 0);

    // Reset while pressed, with tick asserted during reset
    settle(7'h01);
    cyc();
    check("mid_press", press_pulse, 1);
    rst  = 1'b1;
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    check("mid_rst_deb",     btn_deb,       0);
    check("mid_rst_held",    any_held,      0);
    check("mid_rst_release", release_pulse, 0);
    rst = 1'b0;
    cyc();
    check("mid_no_release", release_pulse, 0);
    repeat (3) tick8();
    check("mid_redeb_wait", btn_deb, 7'h00);
    tick8();
    check("mid_redeb", btn_deb, 7'h01);
    cyc();
    check("mid_repress", press_pulse, 1);
    check("mid_mask",    press_mask,  7'h01);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
